// File: rtl/regfile_pkg.sv
// Shared types and constants for the multi-port register file; no logic, no latency.
package regfile_pkg;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int COUNT_W = 16;
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    function automatic int num_regs(input int reg_bits);
        return 1 << reg_bits;
    endfunction

endpackage

// File: rtl/regfile_clear_seq.sv
// Clear sequencer: zeroes one entry per cycle for NUM_REGS cycles after reset or clear_req.
// busy is registered state; clear_req is ignored while a sequence is already running.
module regfile_clear_seq
    import regfile_pkg::*;
#(
    parameter int REG_BITS = 5
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                clear_req,
    output logic                clr_we,
    output logic [REG_BITS-1:0] clr_index,
    output logic                busy
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [REG_BITS-1:0] r_cnt;
    logic [REG_BITS-1:0] w_cnt_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= CLEAR;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The edge that writes the last index is the one that leaves CLEAR.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        clr_we      = 1'b0;
        clr_index   = r_cnt;
        busy        = 1'b0;
        case (r_state)
            CLEAR: begin
                clr_we    = 1'b1;
                busy      = 1'b1;
                w_cnt_nxt = r_cnt + 1'b1;
                if (&r_cnt) begin
                    w_state_nxt = READY;
                    w_cnt_nxt   = '0;
                end
            end
            READY: begin
                if (clear_req) begin
                    w_state_nxt = CLEAR;
                    w_cnt_nxt   = '0;
                end
            end
            default: w_state_nxt = CLEAR;
        endcase
    end

endmodule

// File: rtl/regfile_mp.sv
// Register file: one write port, READ_PORTS zero-latency read ports, r0 reads zero, built-in clear.
// Writes and reads are ignored/zeroed while busy; define REGFILE_MP_BYPASS_EN for write-through reads.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int REG_BITS   = 5,
    parameter int READ_PORTS = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           write_en,
    input  logic [REG_BITS-1:0]            write_index,
    input  logic [WIDTH-1:0]               write_data,
    input  logic [READ_PORTS*REG_BITS-1:0] read_index,
    output logic [READ_PORTS*WIDTH-1:0]    read_data,
    input  logic                           clear_req,
    output logic                           busy,
    output logic [COUNT_W-1:0]             write_count
);

    localparam int NUM_REGS = num_regs(REG_BITS);

    logic                w_clr_we;
    logic [REG_BITS-1:0] w_clr_index;
    logic                w_busy;
    logic                w_accept;
    logic                w_mem_we;
    logic [REG_BITS-1:0] w_mem_idx;
    logic [WIDTH-1:0]    w_mem_dat;
    logic [WIDTH-1:0]    r_mem [NUM_REGS];
    logic [COUNT_W-1:0]  r_write_count;

    regfile_clear_seq #(
        .REG_BITS (REG_BITS)
    ) u_clear_seq (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear_req (clear_req),
        .clr_we    (w_clr_we),
        .clr_index (w_clr_index),
        .busy      (w_busy)
    );

    // A write coinciding with clear_req is dropped, so it neither lands nor counts.
    assign w_accept  = write_en && !w_busy && !clear_req && (write_index != '0);
    assign w_mem_we  = w_clr_we || w_accept;
    assign w_mem_idx = w_clr_we ? w_clr_index : write_index;
    assign w_mem_dat = w_clr_we ? '0 : write_data;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_dat;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_write_count <= '0;
        end else if (!w_busy && clear_req) begin
            r_write_count <= '0;
        end else if (w_accept && (r_write_count != COUNT_MAX)) begin
            r_write_count <= r_write_count + 1'b1;
        end
    end

    for (genvar p = 0; p < READ_PORTS; p++) begin : g_rd
        logic [REG_BITS-1:0] w_rd_idx;
        assign w_rd_idx = read_index[p*REG_BITS +: REG_BITS];
        always_comb begin
            read_data[p*WIDTH +: WIDTH] = '0;
            if (!w_busy && (w_rd_idx != '0)) begin
`ifdef REGFILE_MP_BYPASS_EN
                if (w_accept && (w_rd_idx == write_index)) begin
                    read_data[p*WIDTH +: WIDTH] = write_data;
                end else begin
                    read_data[p*WIDTH +: WIDTH] = r_mem[w_rd_idx];
                end
`else
                read_data[p*WIDTH +: WIDTH] = r_mem[w_rd_idx];
`endif
            end
        end
    end

    assign busy        = w_busy;
    assign write_count = r_write_count;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: stimulus queues expected outputs, a negedge monitor checks them.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        write_en;
    logic [4:0]  write_index;
    logic [15:0] write_data;
    logic [9:0]  read_index;
    logic [31:0] read_data;
    logic        clear_req;
    logic        busy;
    logic [15:0] write_count;

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   waited   = 0;

    regfile_mp #(
        .WIDTH      (16),
        .REG_BITS   (5),
        .READ_PORTS (2)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .write_en    (write_en),
        .write_index (write_index),
        .write_data  (write_data),
        .read_index  (read_index),
        .read_data   (read_data),
        .clear_req   (clear_req),
        .busy        (busy),
        .write_count (write_count)
    );

    always #5 clk = ~clk;

    // kind: 0 = read port 0, 1 = read port 1, 2 = busy, 3 = write_count
    task automatic expect_out(input int kind, input logic [15:0] exp, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic check_now(input logic [15:0] act, input logic [15:0] exp, input string name);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = q.pop_front();
            case (e.kind)
                0:       act = read_data[15:0];
                1:       act = read_data[31:16];
                2:       act = {15'd0, busy};
                default: act = write_count;
            endcase
            n_checks++;
            if (act === e.exp) n_pass++;
            else $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
        end
    end

    // Checks busy/read-zero for a full clear window, optionally firing a write or clear_req inside it.
    task automatic run_clear(input string tag, input int wr_cycle, input int req_cycle);
        for (int i = 0; i < 32; i++) begin
            write_en  = (i == wr_cycle);
            clear_req = (i == req_cycle);
            expect_out(2, 16'h0001, {tag, "_busy"});
            expect_out(0, 16'h0000, {tag, "_rd0_zero"});
            expect_out(3, 16'h0000, {tag, "_wc_zero"});
            step();
        end
        write_en  = 1'b0;
        clear_req = 1'b0;
        expect_out(2, 16'h0000, {tag, "_busy_done"});
    endtask

    initial begin
        reset_n     = 1'b0;
        write_en    = 1'b0;
        write_index = '0;
        write_data  = '0;
        read_index  = {5'd9, 5'd3};
        clear_req   = 1'b0;
        #1;
        check_now({15'd0, busy}, 16'h0001, "reset_busy_now");
        check_now(write_count, 16'h0000, "reset_wc_now");
        expect_out(2, 16'h0001, "reset_busy");
        expect_out(3, 16'h0000, "reset_wc");
        step();
        step();
        reset_n = 1'b1;
        run_clear("init", -1, -1);

        waited = 0;
        while ((busy !== 1'b0) && (waited < 40)) begin
            step();
            waited++;
        end
        n_checks++;
        if ((busy === 1'b0) && (waited == 0)) n_pass++;
        else $display("FAIL busy_wait_expired: busy=%b after %0d extra cycles at %0t", busy, waited, $time);
        step();

        // Write BEEF to r5, then read it on both ports.
        write_en = 1'b1; write_index = 5'd5; write_data = 16'hBEEF;
        step();
        write_en = 1'b0; read_index = {5'd5, 5'd5};
        expect_out(0, 16'hBEEF, "r5_port0");
        expect_out(1, 16'hBEEF, "r5_port1");
        expect_out(3, 16'd1, "wc_after_r5");
        step();

        // Write to r0 is discarded.
        write_en = 1'b1; write_index = 5'd0; write_data = 16'h1234;
        step();
        write_en = 1'b0; read_index = {5'd0, 5'd0};
        expect_out(0, 16'h0000, "r0_port0");
        expect_out(1, 16'h0000, "r0_port1");
        expect_out(3, 16'd1, "wc_r0_unchanged");
        step();

        // Read-during-write on r7.
        write_en = 1'b1; write_index = 5'd7; write_data = 16'h0001;
        step();
        write_data = 16'hAAAA; read_index = {5'd5, 5'd7};
`ifdef REGFILE_MP_BYPASS_EN
        expect_out(0, 16'hAAAA, "r7_same_cycle");
`else
        expect_out(0, 16'h0001, "r7_same_cycle");
`endif
        expect_out(1, 16'hBEEF, "r5_unaffected");
        expect_out(3, 16'd2, "wc_before_r7b");
        step();
        write_en = 1'b0;
        expect_out(0, 16'hAAAA, "r7_next_cycle");
        expect_out(3, 16'd3, "wc_after_r7b");
        step();

        // r3 write, then clear_req with a coincident (dropped) write to r4.
        write_en = 1'b1; write_index = 5'd3; write_data = 16'h00FF;
        step();
        read_index = {5'd4, 5'd3};
        write_index = 5'd4; write_data = 16'h5555; clear_req = 1'b1;
        expect_out(0, 16'h00FF, "r3_before_clear");
        expect_out(1, 16'h0000, "r4_before_clear");
        expect_out(2, 16'h0000, "busy_before_req");
        expect_out(3, 16'd4, "wc_before_req");
        step();
        clear_req = 1'b0; write_data = 16'h9999;
        run_clear("req", 5, -1);
        expect_out(0, 16'h0000, "r3_after_clear");
        expect_out(1, 16'h0000, "r4_after_clear");
        expect_out(3, 16'h0000, "wc_after_clear");
        step();

        // Reset in mid-clear restarts; clear_req inside the clear does not extend it.
        write_en = 1'b1; write_index = 5'd9; write_data = 16'h1111;
        step();
        write_en = 1'b0; read_index = {5'd9, 5'd9};
        expect_out(0, 16'h1111, "r9_written");
        expect_out(3, 16'd1, "wc_r9");
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        reset_n = 1'b0;
        expect_out(2, 16'h0001, "midreset_busy");
        expect_out(3, 16'h0000, "midreset_wc");
        step();
        reset_n = 1'b1;
        run_clear("restart", -1, 3);
        expect_out(0, 16'h0000, "r9_after_restart");
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write, dual-read register file.
- Dedicated write index, N combinational read ports, register 0 hardwired to zero.
- Built-in clear sequencer zeroes the whole array after reset or on request.
- Sits between decode and ALU in the datapath; the control FSM consults `busy` before issuing reads.

Parameters:
- WIDTH, 16, data width of each register.
- REG_BITS, 5, index width; array depth is NUM_REGS = 1<<REG_BITS.
- READ_PORTS, 2, number of independent combinational read ports (1..4).

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- write_en  input  1  write strobe, sampled on rising clk.
- write_index  input  REG_BITS  destination register.
- write_data  input  WIDTH  data to write.
- read_index  input  READ_PORTS*REG_BITS  packed read indices; port p occupies bits [p*REG_BITS +: REG_BITS].
- read_data  output  READ_PORTS*WIDTH  packed read data; port p occupies bits [p*WIDTH +: WIDTH].
- clear_req  input  1  single-cycle pulse requesting a full array clear.
- busy  output  1  high while the clear sequence runs.
- write_count  output  16  saturating count of accepted writes since the last clear.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- FSM states:
  - CLEAR: counter walks indices 0..NUM_REGS-1, writing zero to one entry per cycle.
  - READY: normal operation.
- Reset entry: reset_n low asynchronously forces state=CLEAR, clear counter=0, busy=1, write_count=0.
- Clear sequence:
  - After reset_n rises, CLEAR lasts exactly NUM_REGS cycles (32 at defaults).
  - busy falls on the edge that writes index NUM_REGS-1; READY follows.
  - Reset asserted mid-clear restarts the sequence at index 0.
- clear_req:
  - In READY: next edge enters CLEAR with counter=0 and busy=1; write_count returns to 0 when the sequence starts.
  - In CLEAR: ignored (no restart, no extension).
  - A write presented in the same cycle as clear_req is dropped.
- Writes in READY:
  - write_en=1 with write_index!=0 updates the entry on the rising edge.
  - write_index=0 is discarded and not counted.
  - Each accepted write increments write_count, which saturates at 16'hFFFF.
- Writes in CLEAR are discarded and not counted.
- Reads:
  - Combinational, zero latency.
  - Port p returns 0 when its index is 0 or busy=1; otherwise returns the array entry.
  - Multiple ports may address the same index; each returns identical data.
- Read/write same cycle without bypass: a read returns the pre-write value; the new value is visible the cycle after the edge.
- Array storage is not reset directly; zeroing happens only through the sequencer. This keeps the array inferable as distributed RAM.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined: write-through bypass. When write_en=1, state=READY, write_index!=0 and read_index[p]==write_index, read_data[p]=write_data in the same cycle. Bypass is suppressed when clear_req=1, since that write is dropped.
- Undefined: no bypass; reads always see array contents as described above.

Decomposition:
- Package regfile_pkg:
  - State enum {CLEAR, READY}.
  - Function num_regs(REG_BITS).
  - Constant COUNT_W=16 and COUNT_MAX.
- Sub-module regfile_clear_seq holds the FSM, clear counter and busy generation.
  - Outputs: clr_we, clr_index and busy.
  - Top level muxes clr_* against the user write port.

Test Plan:
- Release reset, hold clear_req=0 -> busy=1 for exactly 32 cycles, then 0; all read ports return 0 throughout; write_count=0.
- READY; write 16'hBEEF to r5; next cycle set read_index0=5, read_index1=5 -> both ports 16'hBEEF; write_count=1.
- Write 16'h1234 to r0, then read r0 -> 0; write_count unchanged.
- Without bypass, write r7=16'hAAAA while reading r7 (old value 16'h0001) -> 16'h0001 that cycle, 16'hAAAA next. With REGFILE_MP_BYPASS_EN -> 16'hAAAA that same cycle.
- clear_req pulse after writing r3=16'h00FF -> busy high 32 cycles; a write to r4 during the clear is ignored; afterwards r3=0, r4=0, write_count=0.
- Assert reset_n low at clear cycle 10, release -> sequence restarts, busy high 32 more cycles; a second clear_req during CLEAR does not extend it.
